// File: rtl/int_alu_shift_unit_pkg.sv
// -----------------------------------------------------------------------------
// int_alu_shift_unit_pkg
// Shared widths and encodings for the integer ALU / barrel-shifter execution
// unit. The ALU code, shift type and shift-operand type enums give names to
// the raw input fields. Every other file in the unit imports this package.
// -----------------------------------------------------------------------------
package int_alu_shift_unit_pkg;

  localparam int DATA_WIDTH            = 32;
  localparam int SHIFT_AMOUNT_BIT_SIZE = 5;

  // ALU function codes. Codes 9-15 are reserved and produce a zero result.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLT    = 4'd2,
    ALU_SLTU   = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_OR     = 4'd5,
    ALU_AND    = 4'd6,
    ALU_PASS_B = 4'd7,
    ALU_PASS_A = 4'd8
  } int_alu_code_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'd0,
    SHIFT_LSR = 2'd1,
    SHIFT_ASR = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_type_e;

  typedef enum logic {
    SHIFT_OPERAND_IMM = 1'b0,
    SHIFT_OPERAND_REG = 1'b1
  } shift_operand_type_e;

endpackage : int_alu_shift_unit_pkg

// File: rtl/int_alu_shift_unit_alu.sv
// -----------------------------------------------------------------------------
// int_alu_core
// Purely combinational integer ALU. All arithmetic wraps modulo 2^DATA_WIDTH.
// Reserved codes return zero, so the result never carries X.
//   code_i   : ALU function (int_alu_code_e encoding)
//   a_i, b_i : operands
//   result_o : function result
// -----------------------------------------------------------------------------
module int_alu_core
  import int_alu_shift_unit_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic [3:0]    code_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] result_o
);

  always_comb begin
    // NOTE: assigning a default before the case means every path writes
    // result_o, so no latch is inferred for unlisted codes.
    result_o = '0;
    case (code_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_SLT:    result_o = DW'($signed(a_i) < $signed(b_i));
      ALU_SLTU:   result_o = DW'(a_i < b_i);
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_OR:     result_o = a_i | b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_PASS_B: result_o = b_i;
      ALU_PASS_A: result_o = a_i;
      default:    result_o = '0;
    endcase
  end

endmodule : int_alu_core

// File: rtl/int_alu_shift_unit_shifter.sv
// -----------------------------------------------------------------------------
// barrel_shifter
// Purely combinational shifter with an ARM-style carry-out. The shift amount
// comes already selected (immediate or register) from the parent.
//   shift_type_i : LSL / LSR / ASR / ROR (shift_type_e encoding)
//   amt_i        : effective shift amount
//   data_i       : value to shift
//   carry_i      : carry returned unchanged when amt_i == 0
//   data_o       : shifted value
//   carry_o      : last bit shifted out (for ROR, the result MSB)
// -----------------------------------------------------------------------------
module barrel_shifter
  import int_alu_shift_unit_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int SB = SHIFT_AMOUNT_BIT_SIZE
) (
  input  logic [1:0]    shift_type_i,
  input  logic [SB-1:0] amt_i,
  input  logic [DW-1:0] data_i,
  input  logic          carry_i,
  output logic [DW-1:0] data_o,
  output logic          carry_o
);

  // One guard bit catches the last bit shifted out. For a left shift the
  // guard sits above the MSB. For a right shift it sits below the LSB. This
  // avoids indexing data_i with a variable that can go out of range.
  logic [DW:0]   lsl_ext;
  logic [DW:0]   lsr_ext;
  logic [DW-1:0] asr_res;
  logic [DW-1:0] ror_res;
  logic [SB:0]   ror_left;

  assign lsl_ext  = {1'b0, data_i} << amt_i;
  assign lsr_ext  = {data_i, 1'b0} >> amt_i;
  assign asr_res  = $signed(data_i) >>> amt_i;
  assign ror_left = (SB+1)'(DW) - {1'b0, amt_i};
  assign ror_res  = (data_i >> amt_i) | (data_i << ror_left);

  always_comb begin
    // A zero shift passes the data through and returns carry_i for every type.
    data_o  = data_i;
    carry_o = carry_i;
    if (amt_i != '0) begin
      case (shift_type_i)
        SHIFT_LSL: begin
          data_o  = lsl_ext[DW-1:0];
          carry_o = lsl_ext[DW];
        end
        SHIFT_LSR: begin
          data_o  = lsr_ext[DW:1];
          carry_o = lsr_ext[0];
        end
        SHIFT_ASR: begin
          data_o  = asr_res;
          carry_o = lsr_ext[0];  // same bit A[amt-1] as LSR
        end
        default: begin
          data_o  = ror_res;
          carry_o = ror_res[DW-1];
        end
      endcase
    end
  end

endmodule : barrel_shifter

// File: rtl/int_alu_shift_unit.sv
// -----------------------------------------------------------------------------
// int_alu_shift_unit
// Registered integer execution datapath. One ALU and one barrel shifter share
// operands A/B. A result selector picks one of them, and an output register
// captures the result. The unit has a latency of 1 and accepts one op per
// cycle.
//   clk, rst            : clock, synchronous active-high reset
//   stall               : hold all output registers
//   valid_in            : op present this cycle
//   op_sel              : 0 = ALU result, 1 = shifter result
//   alu_code            : ALU function
//   shift_operand_type  : 0 = immediate amount, 1 = op_b low bits
//   shift_type          : LSL / LSR / ASR / ROR
//   imm_shift_amount    : immediate shift amount
//   carry_in            : carry returned on a zero shift
//   op_a, op_b          : operands
//   valid_out, data_out, carry_out : registered results
// -----------------------------------------------------------------------------
module int_alu_shift_unit
  import int_alu_shift_unit_pkg::*;
#(
  parameter int DATA_WIDTH            = int_alu_shift_unit_pkg::DATA_WIDTH,
  parameter int SHIFT_AMOUNT_BIT_SIZE = int_alu_shift_unit_pkg::SHIFT_AMOUNT_BIT_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             valid_in,
  input  logic                             op_sel,
  input  logic [3:0]                       alu_code,
  input  logic                             shift_operand_type,
  input  logic [1:0]                       shift_type,
  input  logic [SHIFT_AMOUNT_BIT_SIZE-1:0] imm_shift_amount,
  input  logic                             carry_in,
  input  logic [DATA_WIDTH-1:0]            op_a,
  input  logic [DATA_WIDTH-1:0]            op_b,
  output logic                             valid_out,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             carry_out
);

  logic [SHIFT_AMOUNT_BIT_SIZE-1:0] shift_amt;
  logic [DATA_WIDTH-1:0]            alu_result;
  logic [DATA_WIDTH-1:0]            shift_result;
  logic                             shift_carry;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  carry_q, carry_d;

  // The register amount uses only the low bits of op_b. The upper bits are
  // ignored.
  assign shift_amt = (shift_operand_type == SHIFT_OPERAND_REG)
                   ? op_b[SHIFT_AMOUNT_BIT_SIZE-1:0]
                   : imm_shift_amount;

  int_alu_core #(
    .DW (DATA_WIDTH)
  ) u_alu (
    .code_i   (alu_code),
    .a_i      (op_a),
    .b_i      (op_b),
    .result_o (alu_result)
  );

  barrel_shifter #(
    .DW (DATA_WIDTH),
    .SB (SHIFT_AMOUNT_BIT_SIZE)
  ) u_shifter (
    .shift_type_i (shift_type),
    .amt_i        (shift_amt),
    .data_i       (op_a),
    .carry_i      (carry_in),
    .data_o       (shift_result),
    .carry_o      (shift_carry)
  );

  // The result loads even when valid_in is 0. Consumers qualify the result
  // with valid_out.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    carry_d = carry_q;
    if (!stall) begin
      valid_d = valid_in;
      data_d  = op_sel ? shift_result : alu_result;
      carry_d = op_sel ? shift_carry  : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop
    // samples pre-edge values and the simulation is free of ordering races.
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign carry_out = carry_q;

endmodule : int_alu_shift_unit

// File: tb/tb_int_alu_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_int_alu_shift_unit
// Self-checking bench for int_alu_shift_unit. A behavioural model computes the
// expected registered outputs from the input fields, using plain arithmetic
// and a bit-by-bit shift loop. A compare process checks the DUT against the
// model at every falling edge. Directed steps also check hand-computed
// literal results.
// -----------------------------------------------------------------------------
module tb_int_alu_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        valid_in;
  logic        op_sel;
  logic [3:0]  alu_code;
  logic        shift_operand_type;
  logic [1:0]  shift_type;
  logic [4:0]  imm_shift_amount;
  logic        carry_in;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        valid_out;
  logic [31:0] data_out;
  logic        carry_out;

  int vectors     = 0;
  int miscompares = 0;

  // Expected register contents held by the model.
  logic        exp_valid;
  logic [31:0] exp_data;
  logic        exp_carry;
  bit          model_live = 1'b0;

  always #5 clk = ~clk;

  int_alu_shift_unit dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .valid_in           (valid_in),
    .op_sel             (op_sel),
    .alu_code           (alu_code),
    .shift_operand_type (shift_operand_type),
    .shift_type         (shift_type),
    .imm_shift_amount   (imm_shift_amount),
    .carry_in           (carry_in),
    .op_a               (op_a),
    .op_b               (op_b),
    .valid_out          (valid_out),
    .data_out           (data_out),
    .carry_out          (carry_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {carry, data} for the given input fields.
  function automatic logic [32:0] model(input logic sel, input logic [3:0] code,
                                        input logic sot, input logic [1:0] st,
                                        input logic [4:0] imm, input logic cin,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] r;
    logic        c;
    int          amt;
    if (!sel) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (code)
        4'd0: r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
        4'd1: r = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
        4'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        4'd3: r = (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
        4'd4: r = a ^ b;
        4'd5: r = a | b;
        4'd6: r = a & b;
        4'd7: r = b;
        4'd8: r = a;
        default: r = 32'd0;
      endcase
      return {1'b0, r};
    end
    amt = sot ? int'(b % 32) : int'(imm);
    r = a;
    c = cin;
    // Shift one bit at a time. The carry is the last bit that falls off.
    for (int i = 0; i < amt; i++) begin
      case (st)
        2'd0: begin c = r[31]; r = {r[30:0], 1'b0}; end
        2'd1: begin c = r[0];  r = {1'b0, r[31:1]}; end
        2'd2: begin c = r[0];  r = {r[31], r[31:1]}; end
        default: begin c = r[0]; r = {r[0], r[31:1]}; end
      endcase
    end
    return {c, r};
  endfunction

  // Model of the output register.
  always @(posedge clk) begin
    logic [32:0] m;
    m = model(op_sel, alu_code, shift_operand_type, shift_type,
              imm_shift_amount, carry_in, op_a, op_b);
    if (rst) begin
      exp_valid  = 1'b0;
      exp_data   = 32'd0;
      exp_carry  = 1'b0;
      model_live = 1'b1;
    end else if (!stall) begin
      exp_valid = valid_in;
      exp_data  = m[31:0];
      exp_carry = m[32];
    end
  end

  // Compare process: every falling edge once the model has seen reset.
  always @(negedge clk) begin
    if (model_live)
      check("cycle", {30'd0, valid_out, carry_out, data_out},
                     {30'd0, exp_valid, exp_carry, exp_data});
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic sel, input logic [3:0] code, input logic sot,
                       input logic [1:0] st, input logic [4:0] imm, input logic cin,
                       input logic [31:0] a, input logic [31:0] b);
    valid_in           = 1'b1;
    op_sel             = sel;
    alu_code           = code;
    shift_operand_type = sot;
    shift_type         = st;
    imm_shift_amount   = imm;
    carry_in           = cin;
    op_a               = a;
    op_b               = b;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] d,
                            input logic c);
    check(name, {30'd0, valid_out, carry_out, data_out}, {30'd0, v, c, d});
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 2'd0, 5'd0, 1'b0, 32'd5, 32'd7);

    // Reset has priority even with valid_in high.
    step(); expect_out("reset_1", 1'b0, 32'd0, 1'b0);
    step(); expect_out("reset_2", 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    step(); expect_out("add_5_7", 1'b1, 32'd12, 1'b0);

    drive(1'b0, 4'd0, 1'b0, 2'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'd1);
    step(); expect_out("add_wrap", 1'b1, 32'h0, 1'b0);
    drive(1'b0, 4'd1, 1'b0, 2'd0, 5'd0, 1'b0, 32'd3, 32'd5);
    step(); expect_out("sub_3_5", 1'b1, 32'hFFFF_FFFE, 1'b0);
    drive(1'b0, 4'd2, 1'b0, 2'd0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    step(); expect_out("slt", 1'b1, 32'd1, 1'b0);
    drive(1'b0, 4'd3, 1'b0, 2'd0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    step(); expect_out("sltu", 1'b1, 32'd0, 1'b0);
    drive(1'b0, 4'd6, 1'b0, 2'd0, 5'd0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step(); expect_out("and", 1'b1, 32'hF000_F000, 1'b0);
    drive(1'b0, 4'd5, 1'b0, 2'd0, 5'd0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step(); expect_out("or", 1'b1, 32'hFFF0_FFF0, 1'b0);
    drive(1'b0, 4'd4, 1'b0, 2'd0, 5'd0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step(); expect_out("xor", 1'b1, 32'h0FF0_0FF0, 1'b0);
    drive(1'b0, 4'd12, 1'b0, 2'd0, 5'd0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    step(); expect_out("reserved", 1'b1, 32'h0, 1'b0);

    drive(1'b1, 4'd0, 1'b0, 2'd0, 5'd1, 1'b0, 32'h8000_0001, 32'h0);
    step(); expect_out("lsl_1", 1'b1, 32'h0000_0002, 1'b1);
    drive(1'b1, 4'd0, 1'b0, 2'd1, 5'd1, 1'b0, 32'h8000_0001, 32'h0);
    step(); expect_out("lsr_1", 1'b1, 32'h4000_0000, 1'b1);
    drive(1'b1, 4'd0, 1'b0, 2'd2, 5'd4, 1'b0, 32'h8000_0000, 32'h0);
    step(); expect_out("asr_4", 1'b1, 32'hF800_0000, 1'b0);
    drive(1'b1, 4'd0, 1'b0, 2'd3, 5'd1, 1'b0, 32'h0000_0001, 32'h0);
    step(); expect_out("ror_1", 1'b1, 32'h8000_0000, 1'b1);
    drive(1'b1, 4'd0, 1'b1, 2'd0, 5'd17, 1'b0, 32'h0000_0001, 32'hFFFF_FF23);
    step(); expect_out("lsl_reg_3", 1'b1, 32'h0000_0008, 1'b0);
    drive(1'b1, 4'd0, 1'b1, 2'd1, 5'd9, 1'b1, 32'h1234_5678, 32'hFFFF_FFE0);
    step(); expect_out("amt0_carry", 1'b1, 32'h1234_5678, 1'b1);
    drive(1'b1, 4'd0, 1'b0, 2'd0, 5'd31, 1'b0, 32'h0000_0003, 32'h0);
    step(); expect_out("lsl_31", 1'b1, 32'h8000_0000, 1'b1);

    // Stall: the outputs hold while the inputs change underneath.
    drive(1'b0, 4'd0, 1'b0, 2'd0, 5'd0, 1'b0, 32'd1, 32'd1);
    step(); expect_out("stall_pre", 1'b1, 32'd2, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 5'($urandom),
            1'($urandom), $urandom, $urandom);
      valid_in = 1'($urandom);
      step(); expect_out("stall_hold", 1'b1, 32'd2, 1'b0);
    end
    stall = 1'b0;
    drive(1'b0, 4'd1, 1'b0, 2'd0, 5'd0, 1'b0, 32'd9, 32'd4);
    step(); expect_out("stall_release", 1'b1, 32'd5, 1'b0);

    // A reset in the middle of the stream discards the in-flight op.
    drive(1'b0, 4'd0, 1'b0, 2'd0, 5'd0, 1'b0, 32'd10, 32'd20);
    rst = 1'b1;
    step(); expect_out("reset_mid", 1'b0, 32'd0, 1'b0);
    rst = 1'b0;

    // Random traffic. The first 8 ops run back-to-back. After that, gaps,
    // stalls and occasional resets are mixed in. The compare process checks
    // every cycle.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 2'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
            $urandom, $urandom);
      if ($urandom_range(0, 9) == 0) op_b = op_a;
      if (i >= 8) begin
        valid_in = ($urandom_range(0, 3) != 0);
        stall    = ($urandom_range(0, 9) == 0);
        rst      = ($urandom_range(0, 49) == 0);
      end
      step();
    end
    rst   = 1'b0;
    stall = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_int_alu_shift_unit
